nios_system_pio_in_capture: RTL and testbench
=============================================

Name: nios_system_pio_in_capture

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the team's output PIO blocks.
- Samples an asynchronous external input bus through a two-flop synchronizer.
- Exposes the synchronized level, a per-bit interrupt mask and per-bit edge-capture flags to the Nios II processor.
- Raises a level-sensitive IRQ when any unmasked captured edge is pending.
- Used for pushbuttons/switches and handshake strobes from other system blocks.

Parameters:
- WIDTH, 8: number of input bits; legal range 1..32.
- EDGE_TYPE, 0: edges captured. 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0: reset value loaded into all synchronizer and history flops, WIDTH bits.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select (word address).
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  external asynchronous inputs.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request, active-high, level.

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous, active-low (reset_n). All flops clear on reset_n=0 independent of clk.
- Reset values:
  - sync1, sync2 and prev = RESET_VALUE.
  - irq_mask = 0, edge_capture = 0.
  - readdata = 0, irq = 0.
- Synchronizer: sync1 <= in_port; sync2 <= sync1; prev <= sync2, every clock.
  - An in_port change before clock edge k appears in sync2 after edge k+1.
- Edge detect per bit i:
  - rise = sync2[i] & ~prev[i]
  - fall = ~sync2[i] & prev[i]
  - any = sync2[i] ^ prev[i]
  - The event is selected by EDGE_TYPE. The capture flag sets at edge k+2 after the input change.
- Write = chipselect & ~write_n. Writes take effect at the next clock edge.
- Register map:
  - addr 0, data: read = zero-extended sync2; writes ignored.
  - addr 1, direction: reads 0; writes ignored (input-only PIO).
  - addr 2, irq_mask: RW, bits [WIDTH-1:0]; upper bits read 0 and are ignored on write.
  - addr 3, edge_capture: read = zero-extended flags. A write clears each bit where writedata[i]=1 (write-1-to-clear); bits with writedata[i]=0 are unchanged.
- Simultaneous edge event and W1C clear on the same bit in the same cycle: set wins; the bit stays 1.
- Captured bits stay set until cleared, regardless of further input activity. Repeated edges do not count.
- Read path: readdata <= mux(address) every clock. Read latency is 1 (Avalon readLatency=1).
  - Reading is side-effect free; reading edge_capture does not clear it.
  - readdata for a read issued in the same cycle as a write to the same register returns the pre-write value.
- irq = |(edge_capture & irq_mask), combinational from registers only; no input-to-irq combinational path.
  - irq deasserts the cycle after the last unmasked flag is cleared or masked off.
- Reset mid-operation: pending flags and mask are lost and irq drops immediately (asynchronously).
  - After release, no edge is reported until sync2 differs from prev. An input held at a non-RESET_VALUE level through reset therefore generates one edge 2 clocks after release, if that edge matches EDGE_TYPE.
- Unused writedata/address combinations produce no state change.

Test Plan:
- Reset with in_port=8'hA5, then release -> readdata/irq 0 during reset. A read of addr 0 issued 3 cycles after release returns 32'h000000A5.
- EDGE_TYPE=0, mask=8'h01, in_port 8'h00->8'h01 at cycle 10 -> edge_capture=8'h01 and irq=1 by cycle 12.
  - Write 8'h01 to addr 3 -> irq=0 the next cycle; a readback of addr 3 returns 0.
- in_port bit 3 rises with mask=8'h00 -> edge_capture reads 8'h08 and irq stays 0. Writing mask 8'h08 -> irq=1 the next cycle.
- W1C selectivity: flags 8'h0C, write 8'h04 to addr 3 -> flags read 8'h08.
  - Same-cycle bit-2 rise and W1C of bit 2 -> bit 2 remains 1.
- EDGE_TYPE=1 and EDGE_TYPE=2: a 1->0->1 pulse on bit 0 sets the flag for falling/any only. Under EDGE_TYPE=0 a rising-only edge sets it. A 1-cycle glitch shorter than a clock may be missed without error.
- Reads of addr 1 return 0. Writes to addr 0/1 leave all state unchanged. Asserting reset_n=0 while irq=1 drops irq without waiting for clk.

Source files
------------

// File: rtl/nios_system_pio_in_capture.sv
// rtl/nios_system_pio_in_capture.sv - Avalon-MM input PIO with synchronizer, edge capture and IRQ
module nios_system_pio_in_capture #(
  parameter int              WIDTH       = 8,
  parameter int              EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en = chipselect & ~write_n;
  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
      prev  <= RESET_VALUE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_comb begin
    edge_event = sync2 ^ prev;
    if (EDGE_TYPE == 0) begin
      edge_event = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin
      edge_event = ~sync2 & prev;
    end
  end

  always_comb begin
    clear_bits = '0;
    if (wr_en && address == 2'd3) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  // A new edge in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 2'd2) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clear_bits) | edge_event;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync2;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_system_pio_in_capture.sv
// tb/tb_nios_system_pio_in_capture.sv - directed bench for the input PIO, one instance per EDGE_TYPE
module tb_nios_system_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'h00)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  nios_system_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1), .RESET_VALUE(8'h00)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  nios_system_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = 8'hA5; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    tick(3);
    n_checks++;
    if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h exp %h", rd0, 32'h0); end
    n_checks++;
    if ({irq0, irq1, irq2} !== 3'b000) begin n_fail++; $display("FAIL reset_irq got %b exp 000", {irq0, irq1, irq2}); end
    reset_n = 1'b1;
    tick(2);
    do_read(2'd0);
    n_checks++;
    if (rd0 !== 32'h000000A5) begin n_fail++; $display("FAIL reset_data_read got %h exp %h", rd0, 32'hA5); end
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'hA5) begin n_fail++; $display("FAIL reset_held_edge_rise got %h exp %h", rd0, 32'hA5); end
    n_checks++;
    if (rd1 !== 32'h00) begin n_fail++; $display("FAIL reset_held_edge_fall got %h exp %h", rd1, 32'h0); end
    n_checks++;
    if (rd2 !== 32'hA5) begin n_fail++; $display("FAIL reset_held_edge_any got %h exp %h", rd2, 32'hA5); end
    do_write(2'd3, 32'hFF);
  endtask

  task automatic test_rise_irq;
    in_port = 8'h00;
    tick(4);
    do_write(2'd3, 32'hFF);
    do_write(2'd2, 32'h01);
    in_port = 8'h01;
    tick(2);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early got %b exp 0", irq0); end
    tick(1);
    n_checks++;
    if ({irq0, irq1, irq2} !== 3'b101) begin n_fail++; $display("FAIL rise_irq_types got %b exp 101", {irq0, irq1, irq2}); end
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h01) begin n_fail++; $display("FAIL rise_capture got %h exp %h", rd0, 32'h01); end
    do_write(2'd3, 32'h01);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_irq_after_clear got %b exp 0", irq0); end
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h00) begin n_fail++; $display("FAIL rise_capture_cleared got %h exp %h", rd0, 32'h0); end
  endtask

  task automatic test_mask;
    do_write(2'd3, 32'hFF);
    do_write(2'd2, 32'h00);
    in_port = 8'h09;
    tick(4);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mask_irq_masked got %b exp 0", irq0); end
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h08) begin n_fail++; $display("FAIL mask_capture got %h exp %h", rd0, 32'h08); end
    do_write(2'd2, 32'h08);
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL mask_irq_unmasked got %b exp 1", irq0); end
  endtask

  task automatic test_w1c;
    in_port = 8'h0D;
    tick(4);
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h0C) begin n_fail++; $display("FAIL w1c_pre got %h exp %h", rd0, 32'h0C); end
    do_write(2'd3, 32'h04);
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h08) begin n_fail++; $display("FAIL w1c_selective got %h exp %h", rd0, 32'h08); end
    in_port = 8'h09;
    tick(4);
    do_write(2'd3, 32'hFF);
    in_port = 8'h0D;
    tick(2);
    do_write(2'd3, 32'h04);
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h04) begin n_fail++; $display("FAIL w1c_set_wins got %h exp %h", rd0, 32'h04); end
  endtask

  task automatic test_edge_types;
    do_write(2'd3, 32'hFF);
    in_port = 8'h0C;
    tick(4);
    do_read(2'd3);
    n_checks++;
    if ({rd0[7:0], rd1[7:0], rd2[7:0]} !== 24'h00_01_01) begin
      n_fail++; $display("FAIL edge_fall rise=%h fall=%h any=%h exp 00 01 01", rd0, rd1, rd2);
    end
    do_write(2'd3, 32'hFF);
    in_port = 8'h0D;
    tick(4);
    do_read(2'd3);
    n_checks++;
    if ({rd0[7:0], rd1[7:0], rd2[7:0]} !== 24'h01_00_01) begin
      n_fail++; $display("FAIL edge_rise rise=%h fall=%h any=%h exp 01 00 01", rd0, rd1, rd2);
    end
  endtask

  task automatic test_regs;
    do_read(2'd1);
    n_checks++;
    if (rd0 !== 32'h0) begin n_fail++; $display("FAIL dir_read got %h exp %h", rd0, 32'h0); end
    do_write(2'd0, 32'hFFFFFFFF);
    do_write(2'd1, 32'hFFFFFFFF);
    do_read(2'd2);
    n_checks++;
    if (rd0 !== 32'h08) begin n_fail++; $display("FAIL ignored_write_mask got %h exp %h", rd0, 32'h08); end
    do_read(2'd3);
    n_checks++;
    if (rd0 !== 32'h01) begin n_fail++; $display("FAIL ignored_write_capture got %h exp %h", rd0, 32'h01); end
    do_read(2'd0);
    n_checks++;
    if (rd0 !== 32'h0D) begin n_fail++; $display("FAIL ignored_write_data got %h exp %h", rd0, 32'h0D); end
    do_write(2'd2, 32'hFFFFFF00);
    do_read(2'd2);
    n_checks++;
    if (rd0 !== 32'h00) begin n_fail++; $display("FAIL mask_upper_bits got %h exp %h", rd0, 32'h0); end
  endtask

  task automatic test_async_reset;
    do_write(2'd2, 32'h01);
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL async_pre_irq got %b exp 1", irq0); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({irq0, irq2} !== 2'b00) begin n_fail++; $display("FAIL async_reset_irq got %b exp 00", {irq0, irq2}); end
    n_checks++;
    if (rd0 !== 32'h0) begin n_fail++; $display("FAIL async_reset_readdata got %h exp %h", rd0, 32'h0); end
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_rise_irq;
    test_mask;
    test_w1c;
    test_edge_types;
    test_regs;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
